// File: rtl/imm_gen_pipe_if.sv
// Decode-stage handshake bundle: instruction in (valid/ready + tag), immediate result out.
// master drives instructions and accepts results; slave is the immediate generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a main output register and one skid entry.
// Decode is combinational into the registers; every output comes straight from flops.
module imm_gen_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CSR_IMM = 1
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave io
);
    localparam int unsigned FMT_W   = 3;
    localparam int unsigned INSTR_W = 32;
    localparam bit          IS_RV64 = (XLEN == 64);
    localparam bit          CSR_EN  = (CSR_IMM != 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_Z     = 3'd6,
        FMT_SHAMT = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [INSTR_W-1:0] instr;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               is_shift;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, shamt_w, shamt_x;
    entry_t             dec;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   in_fire, out_fire;

    assign instr    = io.in_instr;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Candidate immediates for every format; the opcode decode picks one
    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u   = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j   = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z   = XLEN'(instr[19:15]);
    assign shamt_w = XLEN'(instr[24:20]);
    assign shamt_x = IS_RV64 ? XLEN'(instr[25:20]) : shamt_w;

    // Opcode decode; illegal results keep imm=0 and fmt NONE from the default
    always_comb begin
        dec     = '0;
        dec.tag = io.in_tag;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            OP_IMM: begin
                if (!is_shift) begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end else if (!IS_RV64 && instr[25]) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = shamt_x;
                end
            end
            OP_IMM32: begin
                if (!IS_RV64) begin
                    dec.illegal = 1'b1;
                end else if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    dec.imm = shamt_w;
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = imm_i;
                end
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = imm_b;
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = imm_j;
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    if (CSR_EN) begin
                        dec.fmt = FMT_Z;
                        dec.imm = imm_z;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
            end
            OP_REG, OP_FENCE: begin
                dec.fmt = FMT_NONE;
            end
            OP_REG32: begin
                dec.illegal = !IS_RV64;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_fire  = io.in_valid && !skid_valid_q;
    assign out_fire = main_valid_q && io.out_ready;

    // Main refills from skid first to keep FIFO order; skid only catches a stalled accept
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_fire || !main_valid_q) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign io.in_ready    = !skid_valid_q;
    assign io.out_valid   = main_valid_q;
    assign io.out_imm     = main_q.imm;
    assign io.out_fmt     = main_q.fmt;
    assign io.out_tag     = main_q.tag;
    assign io.out_illegal = main_q.illegal;
endmodule
